stack_frame_sequencer: RTL and testbench

// - Bus master for the page-1 stack. Executes multi-byte push/pull frames: PHA/PHP, JSR/BRK/IRQ/NMI push, PLA/PLP/RTS/RTI pull.
// - Drives the sp_increment/sp_decrement strobes of the stack pointer register and reads its current value on sp_in.
// - Sits between instruction decode (command side) and the memory bus arbiter (bus side).

---
 rtl/stack_frame_sequencer.sv | 141 ++++++++++++++
 tb/tb_stack_frame_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/stack_frame_sequencer.sv
`default_nettype none
// =============================================================================
// stack_frame_sequencer : page-1 stack push/pull frame engine (6502-style)
// Optional macro STACK_WRAP_DETECT_EN builds the sticky stack_wrap detector.
// Revision: 1.0
// =============================================================================
module stack_frame_sequencer #(
  parameter logic [7:0] STACK_PAGE  = 8'h01,
  parameter int         FRAME_BYTES = 3
) (
  input  logic                     fclk,
  input  logic                     resb,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_push,
  input  logic [1:0]               cmd_len,
  input  logic [8*FRAME_BYTES-1:0] push_data,
  output logic [8*FRAME_BYTES-1:0] pull_data,
  output logic                     done,
  input  logic [7:0]               sp_in,
  output logic                     sp_increment,
  output logic                     sp_decrement,
  output logic                     bus_valid,
  input  logic                     bus_ready,
  output logic                     bus_rw,
  output logic [15:0]              bus_addr,
  output logic [7:0]               bus_wdata,
  input  logic [7:0]               bus_rdata,
  output logic                     stack_wrap
);

  localparam int CW = $clog2(FRAME_BYTES + 1);
  localparam int DW = 8 * FRAME_BYTES;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PUSH_WR  = 3'd1,
    PULL_INC = 3'd2,
    PULL_RD  = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t          state;
  logic            is_push;
  logic [CW-1:0]   len;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   wbuf;
  logic [DW-1:0]   rbuf;
  logic [CW-1:0]   len_clamped;
  logic [CW-1:0]   rd_idx;
  logic [7:0]      wbyte;

  assign len_clamped = (32'(cmd_len) > FRAME_BYTES) ? CW'(FRAME_BYTES) : CW'(cmd_len);
  assign rd_idx      = len - cnt;

  // Pushes go out highest byte first, so the byte on the bus is index cnt-1.
  always_comb begin
    wbyte = 8'h00;
    for (int k = 0; k < FRAME_BYTES; k++) begin
      if (CW'(k + 1) == cnt) wbyte = wbuf[8*k +: 8];
    end
  end

  assign bus_valid    = (state == PUSH_WR) || (state == PULL_RD);
  assign bus_rw       = (state == PULL_RD);
  assign bus_addr     = bus_valid ? {STACK_PAGE, sp_in} : 16'h0000;
  assign bus_wdata    = (state == PUSH_WR) ? wbyte : 8'h00;
  assign sp_decrement = (state == PUSH_WR) && bus_ready;
  assign sp_increment = (state == PULL_INC);
  assign done         = (state == DONE);

  always_ff @(posedge fclk or negedge resb) begin
    if (!resb) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      is_push   <= 1'b0;
      len       <= '0;
      cnt       <= '0;
      wbuf      <= '0;
      rbuf      <= '0;
      pull_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            is_push   <= cmd_push;
            len       <= len_clamped;
            cnt       <= len_clamped;
            wbuf      <= push_data;
            rbuf      <= '0;
            if (len_clamped == '0)  state <= DONE;
            else if (cmd_push)      state <= PUSH_WR;
            else                    state <= PULL_INC;
          end
        end
        PUSH_WR: begin
          if (bus_ready) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= DONE;
          end
        end
        PULL_INC: state <= PULL_RD;
        PULL_RD: begin
          if (bus_ready) begin
            for (int k = 0; k < FRAME_BYTES; k++) begin
              if (CW'(k) == rd_idx) rbuf[8*k +: 8] <= bus_rdata;
            end
            cnt   <= cnt - CW'(1);
            state <= (cnt == CW'(1)) ? DONE : PULL_INC;
          end
        end
        DONE: begin
          // rbuf is cleared on accept, so bytes above len come out as zero.
          if (!is_push) pull_data <= rbuf;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          cmd_ready <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef STACK_WRAP_DETECT_EN
  always_ff @(posedge fclk or negedge resb) begin
    if (!resb) begin
      stack_wrap <= 1'b0;
    end else if ((sp_decrement && sp_in == 8'h00) || (sp_increment && sp_in == 8'hFF)) begin
      stack_wrap <= 1'b1;
    end
  end
`else
  assign stack_wrap = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stack_frame_sequencer.sv
`default_nettype none
// =============================================================================
// tb_stack_frame_sequencer : directed + randomized bench with a frame-level model
// Revision: 1.0
// =============================================================================
module tb_stack_frame_sequencer;

  logic        fclk = 1'b0;
  logic        resb;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_push;
  logic [1:0]  cmd_len;
  logic [23:0] push_data;
  logic [23:0] pull_data;
  logic        done;
  logic [7:0]  sp_in;
  logic        sp_increment;
  logic        sp_decrement;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_rw;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        stack_wrap;

  stack_frame_sequencer dut (
    .fclk(fclk), .resb(resb), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_push(cmd_push), .cmd_len(cmd_len), .push_data(push_data),
    .pull_data(pull_data), .done(done), .sp_in(sp_in),
    .sp_increment(sp_increment), .sp_decrement(sp_decrement),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_rw(bus_rw),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .stack_wrap(stack_wrap)
  );

  always #5 fclk = ~fclk;

  int          ncomp = 0;
  int          nfail = 0;
  logic [7:0]  mem     [256];   // page-1 memory seen by the DUT
  logic [7:0]  ref_mem [256];   // page-1 memory as the model expects it
  logic [23:0] pull_ref = 24'h0;
  bit          ref_wrap = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_wrap(input string tag);
`ifdef STACK_WRAP_DETECT_EN
    check(tag, 32'(stack_wrap), 32'(ref_wrap));
`else
    check(tag, 32'(stack_wrap), 32'd0);
`endif
  endtask

  task automatic run_cmd(input bit push, input int len, input logic [23:0] data,
                         input int forced, input int pct, output int done_c);
    logic [7:0]  s0;
    int          waits, ndec, ninc, bad, step;
    logic [15:0] qa[$];
    logic [7:0]  qd[$];
    logic        qrw[$];
    logic [15:0] pa, wa;
    logic [7:0]  pw, wd;
    logic        prw;
    bit          pstall, wr;
    logic [23:0] exp_pull;
    logic [7:0]  a;
    s0 = sp_in; waits = 0; ndec = 0; ninc = 0; bad = 0; pstall = 0; done_c = -1;
    pa = '0; pw = '0; prw = 1'b0;
    @(negedge fclk);
    cmd_valid = 1'b1; cmd_push = push; cmd_len = 2'(len); push_data = data; bus_ready = 1'b0;
    #1 check("cmd_ready_at_accept", 32'(cmd_ready), 32'd1);
    @(posedge fclk); #1;
    cmd_valid = 1'b0; cmd_push = $urandom_range(1); push_data = 24'($urandom);
    for (int c = 1; c <= 64; c++) begin
      @(negedge fclk);
      bus_ready = (c > forced) && (int'($urandom_range(99)) >= pct);
      #1;
      bus_rdata = (bus_valid && bus_rw) ? mem[bus_addr[7:0]] : 8'h00;
      #1;
      if (sp_increment && sp_decrement) bad++;
      if (pstall && (!bus_valid || bus_addr !== pa || bus_wdata !== pw || bus_rw !== prw)) bad++;
      if (bus_valid && !bus_ready) begin
        waits++;
        if (sp_increment || sp_decrement) bad++;
      end
      if (sp_decrement && !(bus_valid && bus_ready && !bus_rw)) bad++;
      pstall = bus_valid && !bus_ready; pa = bus_addr; pw = bus_wdata; prw = bus_rw;
      if (bus_valid && bus_ready) begin
        qa.push_back(bus_addr);
        qd.push_back(bus_rw ? bus_rdata : bus_wdata);
        qrw.push_back(bus_rw);
      end
      ndec += int'(sp_decrement);
      ninc += int'(sp_increment);
      step = sp_increment ? 1 : (sp_decrement ? -1 : 0);
      wr = bus_valid && bus_ready && !bus_rw; wa = bus_addr; wd = bus_wdata;
      if (done) done_c = c;
      @(posedge fclk); #1;
      sp_in = sp_in + 8'(step);
      if (wr) mem[wa[7:0]] = wd;
      if (done_c >= 0) break;
    end
    bus_ready = 1'b0;

    // Frame-level model: push writes bytes len-1..0 downward from s0,
    // pull reads upward from s0+1 into bytes 0..len-1.
    exp_pull = 24'h0;
    check("done_cycle", 32'(done_c),
          (len == 0) ? 32'd1 : (push ? 32'(len + 1 + waits) : 32'(2 * len + 1 + waits)));
    check("xfer_count", 32'(qa.size()), 32'(len));
    for (int j = 0; j < len; j++) begin
      a = push ? 8'(s0 - 8'(j)) : 8'(s0 + 8'(j) + 8'd1);
      if (push) begin
        ref_mem[a] = data[8*(len-1-j) +: 8];
        if (a == 8'h00) ref_wrap = 1'b1;
      end else begin
        exp_pull[8*j +: 8] = ref_mem[a];
        if (a == 8'h00) ref_wrap = 1'b1;
      end
      if (j < qa.size()) begin
        check("bus_addr", 32'(qa[j]), 32'({8'h01, a}));
        check("bus_rw", 32'(qrw[j]), push ? 32'd0 : 32'd1);
        check("bus_byte", 32'(qd[j]), 32'(ref_mem[a]));
      end
    end
    if (!push) pull_ref = exp_pull;
    check("dec_count", 32'(ndec), push ? 32'(len) : 32'd0);
    check("inc_count", 32'(ninc), push ? 32'd0 : 32'(len));
    check("sp_final", 32'(sp_in), push ? 32'(8'(s0 - 8'(len))) : 32'(8'(s0 + 8'(len))));
    check("protocol_errs", 32'(bad), 32'd0);
    check("pull_data", 32'(pull_data), 32'(pull_ref));
    check_wrap("stack_wrap");
  endtask

  initial begin
    int          dc;
    logic [15:0] ra;
    logic [7:0]  rw;
    resb = 1'b0; cmd_valid = 1'b0; cmd_push = 1'b0; cmd_len = 2'd0;
    push_data = 24'h0; bus_ready = 1'b0; bus_rdata = 8'h00; sp_in = 8'hFD;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    #12;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_bus_valid", 32'(bus_valid), 32'd0);
    check("rst_strobes", 32'({sp_increment, sp_decrement}), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pull_data", 32'(pull_data), 32'd0);
    check("rst_bus_addr", 32'(bus_addr), 32'd0);
    check("rst_stack_wrap", 32'(stack_wrap), 32'd0);
    @(negedge fclk); resb = 1'b1;
    @(posedge fclk); #1;
    check("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

    // Frame push/pull round trip, then wait states.
    run_cmd(1'b1, 3, 24'h1234A5, 0, 0, dc);
    check("t1_done_cycle", 32'(dc), 32'd4);
    check("t1_sp", 32'(sp_in), 32'h0FA);
    run_cmd(1'b0, 3, 24'h0, 0, 0, dc);
    check("t2_done_cycle", 32'(dc), 32'd7);
    check("t2_pull_data", 32'(pull_data), 32'h1234A5);
    run_cmd(1'b1, 1, 24'h00005A, 2, 0, dc);
    check("t3_done_cycle", 32'(dc), 32'd4);

    // SP wrap through 8'h00.
    sp_in = 8'h00;
    check_wrap("t4_wrap_before");
    run_cmd(1'b1, 1, 24'h00005A, 0, 0, dc);
    check("t4_sp_after_push", 32'(sp_in), 32'h0FF);
    run_cmd(1'b0, 1, 24'h0, 0, 0, dc);
    check("t4_pull_data", 32'(pull_data), 32'h00005A);
`ifdef STACK_WRAP_DETECT_EN
    check("t4_wrap_set", 32'(stack_wrap), 32'd1);
`else
    check("t4_wrap_off", 32'(stack_wrap), 32'd0);
`endif

    // Reset during the second byte of a push 3.
    sp_in = 8'h40;
    @(negedge fclk);
    cmd_valid = 1'b1; cmd_push = 1'b1; cmd_len = 2'd3; push_data = 24'hC0FFEE; bus_ready = 1'b1;
    @(posedge fclk); #1; cmd_valid = 1'b0;
    @(negedge fclk); #1;
    ra = bus_addr; rw = bus_wdata;
    check("t5_first_addr", 32'(ra), 32'h0140);
    check("t5_first_data", 32'(rw), 32'h0C0);
    @(posedge fclk); #1;
    sp_in = 8'h3F; mem[ra[7:0]] = rw; ref_mem[8'h40] = 8'hC0;
    @(negedge fclk); #1;
    check("t5_second_valid", 32'(bus_valid), 32'd1);
    resb = 1'b0; #1;
    check("t5_rst_bus_valid", 32'(bus_valid), 32'd0);
    check("t5_rst_strobes", 32'({sp_increment, sp_decrement}), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    bus_ready = 1'b0; ref_wrap = 1'b0;
    @(negedge fclk); resb = 1'b1;
    @(posedge fclk); #1;
    check("t5_cmd_ready", 32'(cmd_ready), 32'd1);
    check("t5_wrap_cleared", 32'(stack_wrap), 32'd0);
    pull_ref = 24'h0;
    run_cmd(1'b1, 1, 24'h000077, 0, 0, dc);

    // Zero-length frames.
    run_cmd(1'b0, 2, 24'h0, 0, 0, dc);
    run_cmd(1'b1, 0, 24'hABCDEF, 0, 0, dc);
    check("t6_push0_done", 32'(dc), 32'd1);
    run_cmd(1'b0, 0, 24'h0, 0, 0, dc);

    // Randomized frames with random wait states.
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(3) == 0) sp_in = 8'($urandom);
      run_cmd(1'($urandom_range(1)), int'($urandom_range(3)), 24'($urandom), 0, 30, dc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
`default_nettype wire
